regfile_retire_scheduler: RTL
=============================

# regfile_retire_scheduler

Sequences retirement writes into the 16-entry architectural register file and maintains its busy/owner status. It accepts up to two retirement results per cycle from the reorder buffer into an 8-entry in-order queue, drains up to three per cycle onto the register file's three write ports, and never issues two writes to the same register in one cycle. It also keeps the per-register busy bit and 4-bit owner tag. Dispatch sets them; a matching retirement clears them.

## Interface
- DEPTH, 8, queue entries (power of two)
- WR_PORTS, 3, register file write ports
- NREGS, 16, architectural registers
- TAG_W, 4, ROB tag width
- DATA_W, 16, register data width

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- retire_valid[0:1]  in  1 each  retirement request; port 0 is older than port 1
- retire_reg[0:1]  in  4 each  destination register
- retire_tag[0:1]  in  4 each  ROB tag of retiring instruction
- retire_data[0:1]  in  16 each  result value
- retire_ready  out  1  both push ports may fire this cycle
- dispatch_enable  in  1  rename a destination register
- dispatch_reg  in  4  register being renamed
- dispatch_tag  in  4  new owner tag
- flush  in  1  drop queue and all busy state
- write_enable[0:2]  out  1 each  register file write strobes
- write_reg[0:2]  out  4 each  write target
- write_data[0:2]  out  16 each  write value
- busy_out  out  16  busy bit per register
- owner_out[0:15]  out  4 each  owner tag per register
- fifo_count  out  4  occupied entries, 0..8

## Operation
- Push: when retire_ready=1, each asserted retire_valid[i] enqueues {reg, tag, data}. Port 0 goes ahead of port 1. A lone retire_valid[1] is legal. When retire_ready=0, requests are ignored, and the requester holds them.
- Pop group: look at head entries h0, h1, h2, limited by occupancy, in order.
  - Issue h0 if present.
  - Issue hk only if h(k-1) issued and hk.reg differs from every reg already issued in this group.
  - Stop at the first non-issued entry. Retirement order is strictly preserved.
- Issued entry k drives write port k. Unused ports are driven with write_enable=0. write_reg/write_data for those ports hold their previous values.
- Busy clear: for each issued entry, if busy[reg]=1 and owner[reg]==tag, clear busy[reg]. owner is unchanged.
- Dispatch: sets busy[dispatch_reg]=1 and owner[dispatch_reg]=dispatch_tag.
  - If a clear and a dispatch hit the same register in the same cycle, dispatch wins.
- Pointers: read/write pointers are 3 bits and wrap modulo DEPTH. fifo_count = count + pushes − pops, in the range 0..8.
- Flush (highest priority):
  - fifo_count becomes 0 and all busy bits clear.
  - Pushes, pops and dispatch in that cycle are discarded.
  - write_enable is 0 on the next cycle.
  - owner values are retained.
- Reset values: write_enable all 0, write_reg/write_data 0, busy_out 0, owner_out all 0, fifo_count 0, retire_ready 1.

## Timing
- All outputs are registered.
- retire_ready = (DEPTH − count_next) ≥ 2, registered. It is valid for the cycle after the edge that computed it.
- No bypass: an entry pushed at edge E is eligible for the pop group in the cycle after E.
  - Its write_enable is asserted for one cycle starting at edge E+1.
  - Its busy clear is visible on busy_out from edge E+1.
- Push and pop in the same cycle are both honoured. fifo_count reflects the net result.
- Peak throughput: 3 writes per cycle. Sustained intake: 2 per cycle.
- The register file samples write_* on the following edge. The scheduler adds no further latency.
- Asynchronous reset mid-operation: everything returns to reset values immediately, and queued entries are lost.

## Test plan
- Reset, then push r1 (tag 3, 0x1111) and r2 (tag 4, 0x2222) in one cycle.
  - One cycle later: write_enable=1,1,0; write_reg=1,2; write_data=0x1111, 0x2222.
  - fifo_count returns to 0.
- Enqueue three entries to r5, r5, r6 (tags 1, 2, 3), then stall pushes.
  - Cycle 1: only port 0 writes r5 (tag 1).
  - Cycle 2: r5 (tag 2) on port 0 and r6 on port 1.
- Dispatch r7 tag 9, then retire r7 with tag 8: busy_out[7] stays 1. Retire r7 with tag 9: busy_out[7]=0 one cycle after issue.
  - Retire r7 tag 9 in the same cycle as a dispatch of r7 tag 10: busy=1, owner=10.
- Fill the queue by pushing 2 per cycle while issue is blocked by repeated same-register entries.
  - retire_ready drops when fifo_count ≥ 7.
  - No entry is lost or reordered across pointer wrap.
- With 6 entries queued and several busy bits set, assert flush together with a push.
  - Next cycle: fifo_count=0, busy_out=0, write_enable=0, retire_ready=1.
- Assert rst_n=0 asynchronously while entries are issuing: all outputs return to zero immediately (retire_ready returns to 1).

Source files
------------

// File: rtl/regfile_retire_scheduler.sv
// Retirement write scheduler for a 16-entry register file: queues up to two results per cycle,
// drains up to three per cycle without same-register collisions, and tracks per-register busy/owner.
module regfile_retire_scheduler #(
    parameter int DEPTH    = 8,
    parameter int WR_PORTS = 3,
    parameter int NREGS    = 16,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       retire_valid [2],
    input  logic [$clog2(NREGS)-1:0]   retire_reg   [2],
    input  logic [TAG_W-1:0]           retire_tag   [2],
    input  logic [DATA_W-1:0]          retire_data  [2],
    output logic                       retire_ready,
    input  logic                       dispatch_enable,
    input  logic [$clog2(NREGS)-1:0]   dispatch_reg,
    input  logic [TAG_W-1:0]           dispatch_tag,
    input  logic                       flush,
    output logic                       write_enable [WR_PORTS],
    output logic [$clog2(NREGS)-1:0]   write_reg    [WR_PORTS],
    output logic [DATA_W-1:0]          write_data   [WR_PORTS],
    output logic [NREGS-1:0]           busy_out,
    output logic [TAG_W-1:0]           owner_out    [NREGS],
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REG_W = $clog2(NREGS);

    logic [REG_W-1:0]  q_reg  [DEPTH];
    logic [TAG_W-1:0]  q_tag  [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg, wr_idx1;
    logic [CNT_W-1:0] count_reg, count_next, push_cnt, pop_cnt;
    logic             ready_reg, ready_next;
    logic             push0, push1;

    logic [REG_W-1:0]    head_reg  [WR_PORTS];
    logic [TAG_W-1:0]    head_tag  [WR_PORTS];
    logic [DATA_W-1:0]   head_data [WR_PORTS];
    logic [WR_PORTS-1:0] issue;

    // Pushes are gated by the registered ready, so the requester simply holds when it is low.
    assign push0      = ready_reg && retire_valid[0] && !flush;
    assign push1      = ready_reg && retire_valid[1] && !flush;
    assign wr_idx1    = wr_ptr_reg + PTR_W'(push0);
    assign push_cnt   = CNT_W'(push0) + CNT_W'(push1);
    assign count_next = count_reg + push_cnt - pop_cnt;
    assign ready_next = (count_next <= CNT_W'(DEPTH - 2));

    always_ff @(posedge clk) begin
        if (push0) begin
            q_reg[wr_ptr_reg]  <= retire_reg[0];
            q_tag[wr_ptr_reg]  <= retire_tag[0];
            q_data[wr_ptr_reg] <= retire_data[0];
        end
        if (push1) begin
            q_reg[wr_idx1]  <= retire_reg[1];
            q_tag[wr_idx1]  <= retire_tag[1];
            q_data[wr_idx1] <= retire_data[1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WR_PORTS; gi++) begin : g_head
            logic [PTR_W-1:0] idx;
            assign idx           = rd_ptr_reg + PTR_W'(gi);
            assign head_reg[gi]  = q_reg[idx];
            assign head_tag[gi]  = q_tag[idx];
            assign head_data[gi] = q_data[idx];
        end
    endgenerate

    // In-order group: an entry issues only if every older head entry issued and no register repeats.
    always_comb begin
        issue    = '0;
        issue[0] = (count_reg != '0);
        for (int k = 1; k < WR_PORTS; k++) begin
            issue[k] = issue[k-1] && (count_reg > CNT_W'(k));
            for (int j = 0; j < k; j++) begin
                if (head_reg[j] == head_reg[k]) issue[k] = 1'b0;
            end
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int k = 0; k < WR_PORTS; k++) begin
            if (issue[k]) pop_cnt = pop_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b1;
            for (int k = 0; k < WR_PORTS; k++) begin
                write_enable[k] <= 1'b0;
                write_reg[k]    <= '0;
                write_data[k]   <= '0;
            end
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b1;
            for (int k = 0; k < WR_PORTS; k++) write_enable[k] <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop_cnt);
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_cnt);
            count_reg  <= count_next;
            ready_reg  <= ready_next;
            for (int k = 0; k < WR_PORTS; k++) begin
                write_enable[k] <= issue[k];
                if (issue[k]) begin
                    write_reg[k]  <= head_reg[k];
                    write_data[k] <= head_data[k];
                end
            end
        end
    end

    assign fifo_count   = count_reg;
    assign retire_ready = ready_reg;

    // Busy/owner per register; a dispatch to the same register overrides a retirement clear.
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic             busy_reg;
            logic [TAG_W-1:0] owner_reg;
            logic             clear_hit;

            always_comb begin
                clear_hit = 1'b0;
                for (int k = 0; k < WR_PORTS; k++) begin
                    if (issue[k] && head_reg[k] == REG_W'(gi) && head_tag[k] == owner_reg)
                        clear_hit = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    busy_reg  <= 1'b0;
                    owner_reg <= '0;
                end else if (flush) begin
                    busy_reg <= 1'b0;
                end else if (dispatch_enable && dispatch_reg == REG_W'(gi)) begin
                    busy_reg  <= 1'b1;
                    owner_reg <= dispatch_tag;
                end else if (clear_hit) begin
                    busy_reg <= 1'b0;
                end
            end

            assign busy_out[gi]  = busy_reg;
            assign owner_out[gi] = owner_reg;
        end
    endgenerate
endmodule
